// File: rtl/ifetch_queue_if.sv
// Fetch-side bus of ifetch_queue: redirect requests, I-cache line port and decode packet.
// master = fetch queue, slave = cache/decode/redirect environment.
`ifndef NOP
`define NOP 32'h0000_0013
`endif

interface ifetch_queue_if #(
  parameter int unsigned XLEN = 32
);
  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] NPC;
    logic            valid;
  } if_id_packet_t;

  logic            certain_branch_req;
  logic [XLEN-1:0] certain_branch_pc;
  logic            rob_target_req;
  logic [XLEN-1:0] rob_target_pc;
  logic            branch_pred_req;
  logic [XLEN-1:0] branch_pred_pc;
  logic            id_ready;
  logic [63:0]     Icache2proc_data;
  logic            Icache2proc_data_valid;
  logic            proc2Icache_req;
  logic [XLEN-1:0] proc2Icache_addr;
  if_id_packet_t   if_packet;

  modport master (
    input  certain_branch_req, certain_branch_pc,
    input  rob_target_req, rob_target_pc,
    input  branch_pred_req, branch_pred_pc,
    input  id_ready, Icache2proc_data, Icache2proc_data_valid,
    output proc2Icache_req, proc2Icache_addr, if_packet
  );

  modport slave (
    output certain_branch_req, certain_branch_pc,
    output rob_target_req, rob_target_pc,
    output branch_pred_req, branch_pred_pc,
    output id_ready, Icache2proc_data, Icache2proc_data_valid,
    input  proc2Icache_req, proc2Icache_addr, if_packet
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: line-fetch FSM (IDLE/REQ/DROP) feeding a circular instruction FIFO.
// Optional macro IFETCH_PERF_EN adds saturating stall-cycle and squashed-response counters.
`ifndef NOP
`define NOP 32'h0000_0013
`endif

module ifetch_queue #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     QUEUE_DEPTH = 8,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  ifetch_queue_if.master               bus,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]                  perf_stall_cycles,
  output logic [31:0]                  perf_squash_count
`endif
);
  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam int unsigned EW = 32 + XLEN;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] line_pc;
  logic [XLEN-1:0] target_pc;
  logic [XLEN-1:0] target_word;
  logic            redirect;
  logic [EW-1:0]   mem [QUEUE_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   wr_ptr_nxt;
  logic [PW:0]     count;
  logic [PW:0]     enq_n;
  logic            accept;
  logic            enq_two;
  logic            deq;
  logic            room;
  logic            head_valid;
  logic [EW-1:0]   head;
  logic [XLEN-1:0] pkt_pc;
  logic            unused_bits;

  always_comb begin
    redirect  = 1'b1;
    target_pc = bus.certain_branch_pc;
    if (bus.certain_branch_req)   target_pc = bus.certain_branch_pc;
    else if (bus.rob_target_req)  target_pc = bus.rob_target_pc;
    else if (bus.branch_pred_req) target_pc = bus.branch_pred_pc;
    else                          redirect  = 1'b0;
  end

  assign target_word = {target_pc[XLEN-1:2], 2'b00};
  assign line_pc     = {fetch_pc[XLEN-1:3], 3'b000};
  assign unused_bits = ^{target_pc[1:0], fetch_pc[1:0]};

  // Issue only with two free slots so a full line response always fits.
  assign room       = count <= (PW+1)'(QUEUE_DEPTH - 2);
  assign head_valid = count != '0;
  assign accept     = (state == REQ) && bus.Icache2proc_data_valid && !redirect;
  assign enq_two    = accept && !fetch_pc[2];
  assign enq_n      = {{(PW-1){1'b0}}, enq_two, accept & ~enq_two};
  assign deq        = head_valid && bus.id_ready;
  assign wr_ptr_nxt = wr_ptr + 1'b1;

  assign head        = mem[rd_ptr];
  assign pkt_pc      = head_valid ? head[XLEN-1:0] : {XLEN{1'b0}};
  assign bus.if_packet = {head_valid ? head[EW-1:XLEN] : `NOP, pkt_pc, pkt_pc + XLEN'(4), head_valid};
  assign queue_count   = count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      fetch_pc             <= {RESET_PC[XLEN-1:2], 2'b00};
      bus.proc2Icache_req  <= 1'b0;
      bus.proc2Icache_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= target_word;
          end else if (room) begin
            state                <= REQ;
            bus.proc2Icache_req  <= 1'b1;
            bus.proc2Icache_addr <= line_pc;
          end
        end
        REQ: begin
          if (redirect) begin
            fetch_pc <= target_word;
            if (bus.Icache2proc_data_valid) begin
              state               <= IDLE;
              bus.proc2Icache_req <= 1'b0;
            end else begin
              state <= DROP;
            end
          end else if (bus.Icache2proc_data_valid) begin
            fetch_pc            <= line_pc + XLEN'(8);
            state               <= IDLE;
            bus.proc2Icache_req <= 1'b0;
          end
        end
        DROP: begin
          // Request stays asserted with the old address until its response is swallowed.
          if (redirect) fetch_pc <= target_word;
          if (bus.Icache2proc_data_valid) begin
            state               <= IDLE;
            bus.proc2Icache_req <= 1'b0;
          end
        end
        default: begin
          state               <= IDLE;
          bus.proc2Icache_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      wr_ptr <= wr_ptr + enq_n[PW-1:0];
      count  <= count + enq_n - (PW+1)'(deq);
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      if (enq_two) begin
        mem[wr_ptr]     <= {bus.Icache2proc_data[31:0], line_pc};
        mem[wr_ptr_nxt] <= {bus.Icache2proc_data[63:32], line_pc + XLEN'(4)};
      end else begin
        mem[wr_ptr]     <= {bus.Icache2proc_data[63:32], line_pc + XLEN'(4)};
      end
    end
  end

`ifdef IFETCH_PERF_EN
  logic squash;
  assign squash = bus.Icache2proc_data_valid && (((state == REQ) && redirect) || (state == DROP));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_stall_cycles <= '0;
      perf_squash_count <= '0;
    end else begin
      if ((state != IDLE) && (perf_stall_cycles != '1)) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (squash && (perf_squash_count != '1))          perf_squash_count <= perf_squash_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: a queue-of-PCs model checked every cycle, a responding I-cache,
// and directed redirect/flush/reset scenarios with literal expectations.
module tb_ifetch_queue;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 8;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  queue_count;
  int unsigned errors = 0;
  int unsigned checks = 0;

  logic        cache_en = 1'b0;
  logic        force_dv = 1'b0;
  logic        answered = 1'b0;
  int unsigned lat      = 0;
  int unsigned wait_cnt = 0;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_squash_count;
`endif

  always #5 clock = ~clock;

  ifetch_queue_if #(.XLEN(XLEN)) bus ();

  ifetch_queue #(
    .XLEN        (XLEN),
    .QUEUE_DEPTH (DEPTH),
    .RESET_PC    (32'h0)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .bus               (bus),
    .queue_count       (queue_count)
`ifdef IFETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_squash_count (perf_squash_count)
`endif
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  function automatic logic [63:0] line_data(input logic [31:0] line);
    return {inst_of(line + 32'd4), inst_of(line)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // I-cache: one response per request, lat cycles after the request is first seen.
  always @(posedge clock) begin
    #1;
    bus.Icache2proc_data_valid = 1'b0;
    if (force_dv) begin
      bus.Icache2proc_data_valid = 1'b1;
      bus.Icache2proc_data       = line_data(32'h0);
    end else if (!bus.proc2Icache_req) begin
      answered = 1'b0;
      wait_cnt = 0;
    end else if (cache_en && !answered) begin
      if (wait_cnt >= lat) begin
        bus.Icache2proc_data_valid = 1'b1;
        bus.Icache2proc_data       = line_data(bus.proc2Icache_addr);
        answered                   = 1'b1;
      end else begin
        wait_cnt++;
      end
    end
  end

  // Model: FIFO of fetched PCs; a response lands only if no redirect hit its request window.
  logic [31:0] m_q[$];
  logic [31:0] m_pc     = 32'h0;
  bit          m_squash = 1'b0;
  logic        m_red;
  logic        m_acc;
  logic [31:0] m_tgt;
  logic [31:0] m_line;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_pc     = 32'h0;
      m_squash = 1'b0;
    end else begin
      m_red = bus.certain_branch_req | bus.rob_target_req | bus.branch_pred_req;
      m_tgt = bus.certain_branch_req ? bus.certain_branch_pc :
              bus.rob_target_req     ? bus.rob_target_pc     : bus.branch_pred_pc;
      m_tgt[1:0] = 2'b00;
      m_line = {m_pc[31:3], 3'b000};
      m_acc  = 1'b0;
      if (bus.proc2Icache_req) begin
        if (bus.Icache2proc_data_valid) begin
          m_acc    = !m_red && !m_squash;
          m_squash = 1'b0;
        end else if (m_red) begin
          m_squash = 1'b1;
        end
      end
      if (m_red) begin
        m_q.delete();
        m_pc = m_tgt;
      end else begin
        if (m_q.size() != 0 && bus.id_ready) void'(m_q.pop_front());
        if (m_acc) begin
          if (!m_pc[2]) m_q.push_back(m_line);
          m_q.push_back(m_line + 32'd4);
          m_pc = m_line + 32'd8;
        end
      end
    end
  end

  logic        prev_req   = 1'b0;
  logic [31:0] prev_addr  = 32'h0;
  int unsigned prev_count = 0;
  int unsigned n;

  always @(negedge clock) begin
    if (!reset) begin
      prev_req   = 1'b0;
      prev_count = 0;
    end else begin
      n = m_q.size();
      check("count", 64'(queue_count), 64'(n));
      check("valid", 64'(bus.if_packet.valid), 64'(n != 0));
      if (n != 0) begin
        check("pc",   64'(bus.if_packet.PC),   64'(m_q[0]));
        check("inst", 64'(bus.if_packet.inst), 64'(inst_of(m_q[0])));
        check("npc",  64'(bus.if_packet.NPC),  64'(m_q[0] + 32'd4));
      end else begin
        check("inst_nop", 64'(bus.if_packet.inst), 64'(NOP_INST));
      end
      if (bus.proc2Icache_req) begin
        if (!prev_req) begin
          check("req_addr", 64'(bus.proc2Icache_addr), 64'({m_pc[31:3], 3'b000}));
          check("req_room", 64'(prev_count <= DEPTH - 2), 64'(1));
        end else begin
          check("addr_stable", 64'(bus.proc2Icache_addr), 64'(prev_addr));
        end
      end
      prev_req   = bus.proc2Icache_req;
      prev_addr  = bus.proc2Icache_addr;
      prev_count = n;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_redirects();
    bus.certain_branch_req = 1'b0;
    bus.certain_branch_pc  = 32'h0;
    bus.rob_target_req     = 1'b0;
    bus.rob_target_pc      = 32'h0;
    bus.branch_pred_req    = 1'b0;
    bus.branch_pred_pc     = 32'h0;
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    clear_redirects();
    bus.id_ready = 1'b0;
    cache_en     = 1'b0;
    force_dv     = 1'b0;
    lat          = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_req(input logic level, input int unsigned max, input string name);
    int unsigned k = 0;
    @(negedge clock);
    while (bus.proc2Icache_req !== level && k < max) begin
      @(negedge clock);
      k++;
    end
    check(name, 64'(bus.proc2Icache_req), 64'(level));
  endtask

  task automatic wait_count(input int unsigned min, input int unsigned max, input string name);
    int unsigned k = 0;
    @(negedge clock);
    while (queue_count < min && k < max) begin
      @(negedge clock);
      k++;
    end
    check(name, 64'(queue_count >= min), 64'(1));
  endtask

  initial begin
    bus.Icache2proc_data       = 64'h0;
    bus.Icache2proc_data_valid = 1'b0;

    // Straight-line fetch from RESET_PC with a 1-cycle cache.
    do_reset();
    cache_en = 1'b1;
    wait_req(1'b1, 10, "t1_req");
    check("t1_addr0", 64'(bus.proc2Icache_addr), 64'h0);
    wait_count(2, 10, "t1_fill2");
    check("t1_count2", 64'(queue_count), 64'd2);
    check("t1_head_pc", 64'(bus.if_packet.PC), 64'h0);
    check("t1_head_inst", 64'(bus.if_packet.inst), 64'hC0DE_0000);
    check("t1_head_npc", 64'(bus.if_packet.NPC), 64'h4);
    check("t1_model_size", 64'(m_q.size()), 64'd2);
    check("t1_model_q1", 64'(m_q[1]), 64'h4);
    wait_req(1'b1, 10, "t1_req2");
    check("t1_addr8", 64'(bus.proc2Icache_addr), 64'h8);

    // Decode stalled: queue fills to depth and requests stop.
    wait_count(DEPTH, 60, "full_fill");
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("full_count", 64'(queue_count), 64'(DEPTH));
      check("full_no_req", 64'(bus.proc2Icache_req), 64'd0);
    end

    // Drain one per cycle with the cache silent, then stream with wrap-around.
    tick();
    cache_en     = 1'b0;
    bus.id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("drain_pc", 64'(bus.if_packet.PC), 64'(i * 4));
    end
    cache_en = 1'b1;
    lat      = 2;
    repeat (40) @(negedge clock);
    lat = 0;
    repeat (20) @(negedge clock);

    // Redirect while the queue holds entries flushes it.
    tick();
    bus.id_ready = 1'b0;
    wait_count(2, 20, "flush_fill");
    tick();
    bus.branch_pred_req = 1'b1;
    bus.branch_pred_pc  = 32'h400;
    tick();
    clear_redirects();
    @(negedge clock);
    check("flush_count", 64'(queue_count), 64'd0);
    check("flush_valid", 64'(bus.if_packet.valid), 64'd0);
    repeat (10) @(negedge clock);

    // Predictor redirect to a mid-line PC.
    do_reset();
    bus.branch_pred_req = 1'b1;
    bus.branch_pred_pc  = 32'h104;
    tick();
    clear_redirects();
    wait_req(1'b1, 10, "t3_req");
    check("t3_addr", 64'(bus.proc2Icache_addr), 64'h100);
    cache_en = 1'b1;
    wait_count(1, 10, "t3_fill");
    check("t3_count", 64'(queue_count), 64'd1);
    check("t3_pc", 64'(bus.if_packet.PC), 64'h104);
    check("t3_inst", 64'(bus.if_packet.inst), 64'hC0DE_0104);
    check("t3_model_size", 64'(m_q.size()), 64'd1);

    // Two redirects together during REQ: certain branch wins, response dropped.
    do_reset();
    wait_req(1'b1, 10, "t4_req");
    tick();
    bus.certain_branch_req = 1'b1;
    bus.certain_branch_pc  = 32'h200;
    bus.rob_target_req     = 1'b1;
    bus.rob_target_pc      = 32'h300;
    tick();
    clear_redirects();
    @(negedge clock);
    check("t4_drop_req", 64'(bus.proc2Icache_req), 64'd1);
    check("t4_drop_addr", 64'(bus.proc2Icache_addr), 64'h0);
    cache_en = 1'b1;
    wait_req(1'b0, 10, "t4_drop_done");
    check("t4_discard", 64'(queue_count), 64'd0);
    wait_req(1'b1, 10, "t4_req2");
    check("t4_addr", 64'(bus.proc2Icache_addr), 64'h200);
`ifdef IFETCH_PERF_EN
    check("t4_squash", 64'(perf_squash_count), 64'd1);
`endif
    wait_count(2, 10, "t4_fill");
    check("t4_pc", 64'(bus.if_packet.PC), 64'h200);

    // Asynchronous reset mid-REQ, then a stray response right after release.
    do_reset();
    wait_req(1'b1, 10, "t5_req");
    #2;
    reset = 1'b0;
    #1;
    check("rst_req", 64'(bus.proc2Icache_req), 64'd0);
    check("rst_valid", 64'(bus.if_packet.valid), 64'd0);
    check("rst_inst", 64'(bus.if_packet.inst), 64'(NOP_INST));
    check("rst_count", 64'(queue_count), 64'd0);
`ifdef IFETCH_PERF_EN
    check("rst_stall", 64'(perf_stall_cycles), 64'd0);
    check("rst_squash", 64'(perf_squash_count), 64'd0);
`endif
    force_dv = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset    = 1'b1;
    force_dv = 1'b0;
    @(negedge clock);
    check("rst_dv_ignored", 64'(queue_count), 64'd0);
    repeat (5) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
